// File: rtl/dm_pkg.sv
// Shared funct3 encodings, FSM state type and funct3 legality check for the
// dm_lsu data memory.
package dm_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Stores only have the signed-looking encodings; loads add the unsigned pair.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction
endpackage

// File: rtl/dm_byte_lanes.sv
// Byte-lane steering for RV32I loads/stores: write mask and replicated write
// data, extracted/extended load data, and the misalignment flag.
module dm_byte_lanes
  import dm_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [31:0] w_shift;

  // Aligned halfwords only ever sit at lane 0 or 2, so one shift serves all sizes.
  assign w_shift = i_rword >> {i_lane, 3'b000};

  always_comb begin
    o_wmask    = 4'b0000;
    o_wdata    = i_wdata;
    o_rdata    = 32'd0;
    o_misalign = 1'b0;
    case (i_f3[1:0])
      2'b00: begin
        o_wmask = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_f3[2] ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        o_misalign = i_lane[0];
        o_wmask    = 4'b0011 << {i_lane[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = i_f3[2] ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      2'b10: begin
        o_misalign = |i_lane;
        o_wmask    = 4'b1111;
        o_rdata    = i_rword;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dm_lsu.sv
// Byte-addressable data memory with RV32I load/store semantics and a
// one-outstanding request/response handshake with RD_LAT load latency.
module dm_lsu
  import dm_pkg::*;
#(
  parameter  int DEPTH  = 32,
  parameter  int RD_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  logic [31:0] r_mem [DEPTH];
  state_t      r_state, w_state_nx;
  logic [1:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [ADDR_W-3:0] w_idx;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata, w_rdata;
  logic              w_misalign, w_err, w_acc;

  assign w_idx = req_addr[ADDR_W-1:2];

  dm_byte_lanes u_lanes (
    .i_f3       (req_funct3),
    .i_lane     (req_addr[1:0]),
    .i_wdata    (req_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  assign w_err     = !f3_legal(req_we, req_funct3) || w_misalign;
  assign req_ready = !rst && (r_state != WAIT);
  assign w_acc     = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_acc && req_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        w_state_nx = IDLE;
        if (w_acc) begin
          if (!req_we && RD_LAT > 1) begin
            w_state_nx = WAIT;
            w_cnt_nx   = 2'd1;
          end else begin
            w_state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == LAT_M1) w_state_nx = RESP;
        else                 w_cnt_nx   = r_cnt + 2'd1;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Load data is captured at accept; the single-outstanding rule keeps it current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_acc) begin
        r_rdata <= (req_we || w_err) ? 32'd0 : w_rdata;
        r_err   <= w_err;
      end
    end
  end
endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: one RD_LAT=1 instance for function and error
// cases, one RD_LAT=3 instance for latency, handshake and mid-wait reset.
module tb_dm_lsu;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [2:0]  req_funct3;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata;

  logic        rst3, v3, rdy3, we3, rv3, err3;
  logic [2:0]  f3_3;
  logic [6:0]  a3;
  logic [31:0] wd3, rd3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_lsu #(.DEPTH(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  dm_lsu #(.DEPTH(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3),
    .req_we(we3), .req_funct3(f3_3), .req_addr(a3),
    .req_wdata(wd3), .rsp_valid(rv3), .rsp_rdata(rd3),
    .rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // RD_LAT=1 transaction; called #1 after a rising edge.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [6:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    chk("ready", req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 6) begin @(posedge clk); #1; n++; end
    chk("rsp_lat", n, 0);
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [6:0] a,
                    input logic [31:0] wd, input logic exp_err);
    logic [31:0] rd; logic er;
    xact(1'b1, f3, a, wd, rd, er);
    chk({tag, "_err"}, er, exp_err);
    chk({tag, "_rd0"}, rd, 0);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [6:0] a,
                    input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] rd; logic er;
    xact(1'b0, f3, a, 32'd0, rd, er);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, er, exp_err);
  endtask

  task automatic ld3(input string tag, input logic [6:0] a, input logic [31:0] exp_d);
    int n;
    chk({tag, "_rdy"}, rdy3, 1);
    v3 = 1; we3 = 0; f3_3 = 3'b010; a3 = a;
    @(posedge clk); #1;
    v3 = 0;
    n = 0;
    while (!rv3 && n < 8) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_data"}, rd3, exp_d);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    rst3 = 1; v3 = 0; we3 = 0; f3_3 = 0; a3 = 0; wd3 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_ready3", rdy3, 0);
    rst = 0; rst3 = 0;
    #1;
    chk("post_rst_ready", req_ready, 1);

    st("sw0", 3'b010, 7'h00, 32'hAAAA_AAAA, 0);
    st("sw4", 3'b010, 7'h04, 32'hBBBB_BBBB, 0);
    ld("lw0", 3'b010, 7'h00, 32'hAAAA_AAAA, 0);
    ld("lw4", 3'b010, 7'h04, 32'hBBBB_BBBB, 0);

    st("sw8", 3'b010, 7'h08, 32'h1122_3344, 0);
    st("sb9", 3'b000, 7'h09, 32'h0000_0080, 0);
    ld("lw8", 3'b010, 7'h08, 32'h1122_8044, 0);
    ld("lb9", 3'b000, 7'h09, 32'hFFFF_FF80, 0);
    ld("lbu9", 3'b100, 7'h09, 32'h0000_0080, 0);
    ld("lbB", 3'b000, 7'h0B, 32'h0000_0011, 0);
    ld("lhuA", 3'b101, 7'h0A, 32'h0000_1122, 0);

    st("shE", 3'b001, 7'h0E, 32'h0000_F00D, 0);
    ld("lhE", 3'b001, 7'h0E, 32'hFFFF_F00D, 0);
    ld("lhuE", 3'b101, 7'h0E, 32'h0000_F00D, 0);
    ld("lwC", 3'b010, 7'h0C, 32'hF00D_0000, 0);

    st("sw2_mis", 3'b010, 7'h02, 32'h1234_5678, 1);
    ld("lh3_mis", 3'b001, 7'h03, 32'h0, 1);
    ld("lw0_keep", 3'b010, 7'h00, 32'hAAAA_AAAA, 0);
    ld("ld_f3_011", 3'b011, 7'h00, 32'h0, 1);
    st("st_f3_011", 3'b011, 7'h00, 32'h5555_5555, 1);
    st("st_f3_100", 3'b100, 7'h00, 32'h5555_5555, 1);
    ld("lw0_keep2", 3'b010, 7'h00, 32'hAAAA_AAAA, 0);

    // store then load of the same word, accepted back-to-back
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 7'h20; req_wdata = 32'h5A5A_1234;
    @(posedge clk); #1;
    chk("b2b_st_vld", rsp_valid, 1);
    chk("b2b_st_err", rsp_err, 0);
    req_we = 0;
    @(posedge clk); #1;
    req_valid = 0;
    chk("b2b_ld_vld", rsp_valid, 1);
    chk("b2b_ld_data", rsp_rdata, 32'h5A5A_1234);
    @(posedge clk); #1;
    chk("b2b_idle", rsp_valid, 0);

    // RD_LAT=3 instance
    v3 = 1; we3 = 1; f3_3 = 3'b010; a3 = 7'h10; wd3 = 32'h1234_5678;
    @(posedge clk); #1;
    v3 = 0;
    chk("l3_st_vld", rv3, 1);
    v3 = 1; we3 = 0; a3 = 7'h10;
    @(posedge clk); #1;
    v3 = 0;
    chk("l3_rdy_t1", rdy3, 0);
    chk("l3_vld_t1", rv3, 0);
    @(posedge clk); #1;
    chk("l3_rdy_t2", rdy3, 0);
    chk("l3_vld_t2", rv3, 0);
    @(posedge clk); #1;
    chk("l3_vld_t3", rv3, 1);
    chk("l3_rdy_t3", rdy3, 1);
    chk("l3_data_t3", rd3, 32'h1234_5678);
    chk("l3_err_t3", err3, 0);
    v3 = 1; we3 = 1; a3 = 7'h14; wd3 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    v3 = 0;
    chk("l3_st_vld_t4", rv3, 1);
    chk("l3_st_err_t4", err3, 0);
    @(posedge clk); #1;
    chk("l3_idle", rv3, 0);
    ld3("l3_lw14", 7'h14, 32'hCAFE_F00D);

    // reset while a load is waiting
    @(posedge clk); #1;
    v3 = 1; we3 = 0; a3 = 7'h10;
    @(posedge clk); #1;
    v3 = 0;
    chk("wr_in_wait", rdy3, 0);
    rst3 = 1;
    #1;
    chk("wr_rst_vld", rv3, 0);
    chk("wr_rst_rdy", rdy3, 0);
    repeat (2) @(posedge clk);
    #1;
    rst3 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_no_rsp", rv3, 0);
      @(posedge clk); #1;
    end
    ld3("wr_lw10", 7'h10, 32'h0);
    ld3("wr_lw14", 7'h14, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_lsu.md
# dm_lsu

Parametrised byte-addressable data memory for the rv32i datapath. Executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) selected by funct3, with byte-lane write masking, load sign/zero extension and misalignment detection. Uses a one-outstanding request/response handshake with configurable read latency. Sits between the execute stage and the writeback mux in place of the fixed word-only data memory.

## Interface
- `DEPTH`, 32: number of 32-bit words; power of two, at least 4.
- `RD_LAT`, 1: load response latency in cycles; legal values 1, 2 and 3.
- `ADDR_W`, localparam $clog2(DEPTH)+2: byte address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; low bytes used for SB/SH.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access or illegal funct3; valid with `rsp_valid`.

## Operation
- Accept occurs when `req_valid && req_ready` at a rising edge (cycle T). Request fields are captured at T.
- Every accepted request produces exactly one response. There is no response backpressure.
- Store funct3 encodings: 000 SB, 001 SH, 010 SW. Any other encoding sets `rsp_err`.
- Load funct3 encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other encoding sets `rsp_err`.
- Misalignment sets `rsp_err`:
  - Halfword access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
- An erroring store writes nothing. An erroring load returns 0.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0].
- Stores write only the addressed bytes:
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lanes {addr[1],0}+1:0.
  - SW writes all four lanes.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane data.
  - LBU/LHU zero-extend.
- FSM states:
  - IDLE: `req_ready`=1. Accepted store goes to RESP. Accepted load goes to WAIT when RD_LAT>1, otherwise RESP.
  - WAIT: `req_ready`=0. A counter runs from 1 to RD_LAT-1, then the FSM goes to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=1.
    - If a new request is accepted, branch as from IDLE.
    - Otherwise go to IDLE.

## Timing
- Store: memory updated at edge T; response in cycle T+1.
- Load: response in cycle T+RD_LAT. Data reflects memory contents at edge T; the one-outstanding rule guarantees no intervening write.
- Back-to-back: a request accepted in the RESP cycle of the previous request is legal. A store accepted at T followed by a load of the same address at T+1 returns the new data.
- Reset (`rst`=1, asynchronous):
  - All memory words clear to 0.
  - State goes to IDLE and the latency counter clears.
  - `req_ready`=0 while `rst` is asserted, then 1 from the first cycle after deassertion.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Reset mid-operation discards the in-flight request; no response is ever issued for it.
- `rsp_rdata` and `rsp_err` are registered. They hold their value outside `rsp_valid` cycles, and the verifier checks them only when `rsp_valid`=1.

## Structure
- Package `dm_pkg` contains:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, WAIT, RESP.
  - Function `f3_legal(we, f3)`.
- Sub-module `dm_byte_lanes` is combinational and computes, from funct3, addr[1:0] and wdata:
  - the 4-bit write mask and lane-shifted write data;
  - the aligned/extended read data from the raw word;
  - the misalign flag.
- Top level contains the storage array, FSM, latency counter and response registers.

## Test plan
- Reset, then SW 0xAAAA_AAAA at 0x00 and SW 0xBBBB_BBBB at 0x04; LW 0x00 and LW 0x04 → 0xAAAA_AAAA and 0xBBBB_BBBB, with `rsp_err`=0.
- SW 0x1122_3344 at 0x08; SB 0x80 at 0x09; then:
  - LW 0x08 → 0x1122_8044.
  - LB 0x09 → 0xFFFF_FF80.
  - LBU 0x09 → 0x0000_0080.
- SH 0xF00D at 0x0E; then:
  - LH 0x0E → 0xFFFF_F00D.
  - LHU 0x0E → 0x0000_F00D.
  - LW 0x0C → 0xF00D_0000.
- SW at 0x02 and LH at 0x03 → `rsp_err`=1 and `rsp_rdata`=0; a following LW 0x00 shows the memory is unchanged. funct3 011 (load or store) → `rsp_err`=1.
- RD_LAT=3 build: load accepted at T → `rsp_valid` only at T+3, `req_ready` low at T+1 and T+2; a store accepted at T+3 → response at T+4.
- Assert `rst` during WAIT → no response pulse is issued; a subsequent LW of any previously written address → 0.
